// File: rtl/reset_seq_gen.sv
// -----------------------------------------------------------------------------
// reset_seq_gen
//
// Purpose
//   Multi-channel reset injector for block and system benches. Drives NUM_CH
//   active-low reset outputs through an IDLE -> ASSERT -> RELEASE -> WAIT
//   sequence, either once (one_shot_req_i) or repeatedly while inject_en_i is
//   held. Hold, period and per-channel release stagger are programmable at
//   run time and are latched when the sequence starts. While a reset is in
//   progress the block presents a default enable vector that bench force
//   logic can apply to the snoop-filter, caching-agent and MR-hint enables.
//
// Ports
//   clk               clock
//   rst_n_cbi         asynchronous, active-low block reset
//   inject_en_i       periodic injection enable (level)
//   one_shot_req_i    single-injection request (pulse, ignored while busy)
//   hold_cycles_i     reset assertion length in cycles (0 behaves as 1)
//   period_cycles_i   gap between last release and next assert (0 behaves as 1)
//   stagger_cycles_i  spacing between successive channel releases
//   ch_mask_i         1 = channel participates in the injection
//   rst_n_out_o       injected resets, active-low
//   busy_o            1 whenever the sequencer is not idle
//   force_active_o    1 from ASSERT entry to RELEASE exit
//   en_force_val_o    EN_DEFAULT while force_active_o=1, else 0
//   inj_cnt_o         number of ASSERT entries, saturating at all-ones
//
// Configuration
//   RESET_SEQ_RAND_HOLD_EN  when defined, a 16-bit Fibonacci LFSR (taps
//                           16,14,13,11, seed 16'hACE1) adds 0-15 random cycles
//                           to every hold. Undefined: hold is exact.
//
// States
//   state      | meaning
//   ST_IDLE    | no sequence in progress, all resets released
//   ST_ASSERT  | masked channels held low for the latched hold length
//   ST_RELEASE | channels released one by one, stagger_q apart
//   ST_WAIT    | gap before the next injection or return to idle
// -----------------------------------------------------------------------------
module reset_seq_gen #(
  parameter int              NUM_CH     = 4,
  parameter int              CNT_W      = 16,
  parameter int              EN_W       = 32,
  parameter logic [EN_W-1:0] EN_DEFAULT = '1,
  parameter int              INJ_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n_cbi,
  input  logic                 inject_en_i,
  input  logic                 one_shot_req_i,
  input  logic [CNT_W-1:0]     hold_cycles_i,
  input  logic [CNT_W-1:0]     period_cycles_i,
  input  logic [CNT_W-1:0]     stagger_cycles_i,
  input  logic [NUM_CH-1:0]    ch_mask_i,
  output logic [NUM_CH-1:0]    rst_n_out_o,
  output logic                 busy_o,
  output logic                 force_active_o,
  output logic [EN_W-1:0]      en_force_val_o,
  output logic [INJ_CNT_W-1:0] inj_cnt_o
);

  // Release countdown must hold (NUM_CH-1)*stagger without wrapping.
  localparam int REL_W = CNT_W + ((NUM_CH > 1) ? $clog2(NUM_CH) : 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W:0]         cnt_q;        // hold / wait down-counter
  logic [REL_W-1:0]       rel_cnt_q;    // cycles remaining until last release
  logic [NUM_CH-1:0]      mask_q;
  logic [CNT_W-1:0]       stagger_q;
  logic [CNT_W-1:0]       period_q;
  logic                   one_shot_q;
  logic [NUM_CH-1:0]      rst_n_out_q;
  logic                   busy_q;
  logic                   force_active_q;
  logic [EN_W-1:0]        en_force_val_q;
  logic [INJ_CNT_W-1:0]   inj_cnt_q;

  logic [CNT_W-1:0]       hold_base_d;
  logic [CNT_W-1:0]       period_base_d;
  logic [CNT_W:0]         hold_load_d;
  logic [CNT_W:0]         period_load_d;
  logic [REL_W-1:0]       stagger_ext_d;
  logic [REL_W-1:0]       rel_last_d;
  logic [REL_W-1:0]       rel_rem_d;
  logic [NUM_CH-1:0]      rel_out_d;
  logic                   assert_start_d;

`ifdef RESET_SEQ_RAND_HOLD_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb_d;

  assign lfsr_fb_d = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

  assign hold_base_d   = (hold_cycles_i == '0) ? CNT_W'(1) : hold_cycles_i;
  assign period_base_d = (period_q == '0) ? CNT_W'(1) : period_q;

`ifdef RESET_SEQ_RAND_HOLD_EN
  assign hold_load_d = {1'b0, hold_base_d} + {{(CNT_W-3){1'b0}}, lfsr_q[3:0]}
                       - (CNT_W+1)'(1);
`else
  assign hold_load_d = {1'b0, hold_base_d} - (CNT_W+1)'(1);
`endif

  assign period_load_d = {1'b0, period_base_d} - (CNT_W+1)'(1);

  assign stagger_ext_d = {{(REL_W-CNT_W){1'b0}}, stagger_q};
  assign rel_last_d    = REL_W'(NUM_CH-1) * stagger_ext_d;

  // Remaining release time in the cycle being scheduled: full span on RELEASE
  // entry, one less each cycle after that.
  assign rel_rem_d = (state_q == ST_ASSERT) ? rel_last_d : (rel_cnt_q - REL_W'(1));

  // Channel i is released once the remaining span drops to (NUM_CH-1-i)*stagger,
  // i.e. exactly i*stagger cycles after RELEASE entry.
  always_comb begin
    rel_out_d = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      rel_out_d[i] = ~mask_q[i] | (rel_rem_d <= (REL_W'(NUM_CH-1-i) * stagger_ext_d));
    end
  end

  // Both inputs high in IDLE counts as periodic; busy-time one-shots are dropped.
  assign assert_start_d =
      ((state_q == ST_IDLE) && (inject_en_i || one_shot_req_i)) ||
      ((state_q == ST_WAIT) && (cnt_q == '0) && inject_en_i && !one_shot_q);

  always_ff @(posedge clk or negedge rst_n_cbi) begin
    if (!rst_n_cbi) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rel_cnt_q      <= '0;
      mask_q         <= '0;
      stagger_q      <= '0;
      period_q       <= '0;
      one_shot_q     <= 1'b0;
      rst_n_out_q    <= '1;
      busy_q         <= 1'b0;
      force_active_q <= 1'b0;
      en_force_val_q <= '0;
      inj_cnt_q      <= '0;
`ifdef RESET_SEQ_RAND_HOLD_EN
      lfsr_q         <= 16'hACE1;
`endif
    end else begin
`ifdef RESET_SEQ_RAND_HOLD_EN
      lfsr_q <= {lfsr_q[14:0], lfsr_fb_d};
`endif
      if (assert_start_d) begin
        state_q        <= ST_ASSERT;
        cnt_q          <= hold_load_d;
        mask_q         <= ch_mask_i;
        stagger_q      <= stagger_cycles_i;
        period_q       <= period_cycles_i;
        one_shot_q     <= ~inject_en_i;
        rst_n_out_q    <= ~ch_mask_i;
        busy_q         <= 1'b1;
        force_active_q <= 1'b1;
        en_force_val_q <= EN_DEFAULT;
        if (inj_cnt_q != '1) begin
          inj_cnt_q <= inj_cnt_q + INJ_CNT_W'(1);
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            busy_q <= 1'b0;
          end
          ST_ASSERT: begin
            if (cnt_q == '0) begin
              state_q     <= ST_RELEASE;
              rel_cnt_q   <= rel_last_d;
              rst_n_out_q <= rel_out_d;
            end else begin
              cnt_q <= cnt_q - (CNT_W+1)'(1);
            end
          end
          ST_RELEASE: begin
            if (rel_cnt_q == '0) begin
              state_q        <= ST_WAIT;
              cnt_q          <= period_load_d;
              rst_n_out_q    <= '1;
              force_active_q <= 1'b0;
              en_force_val_q <= '0;
            end else begin
              rel_cnt_q   <= rel_cnt_q - REL_W'(1);
              rst_n_out_q <= rel_out_d;
            end
          end
          ST_WAIT: begin
            if (cnt_q == '0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - (CNT_W+1)'(1);
            end
          end
          default: begin
            state_q        <= ST_IDLE;
            rst_n_out_q    <= '1;
            busy_q         <= 1'b0;
            force_active_q <= 1'b0;
            en_force_val_q <= '0;
          end
        endcase
      end
    end
  end

  assign rst_n_out_o    = rst_n_out_q;
  assign busy_o         = busy_q;
  assign force_active_o = force_active_q;
  assign en_force_val_o = en_force_val_q;
  assign inj_cnt_o      = inj_cnt_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_reset_seq_gen
//
// Purpose
//   Directed bench for reset_seq_gen (default build, no random hold). Inputs
//   are driven just after the falling edge and outputs sampled on the falling
//   edge, so every sample reflects the state registered at the prior rising
//   edge. Expected lows/busy/force lengths are derived from hold, stagger and
//   period in the bench itself.
// -----------------------------------------------------------------------------
module tb_reset_seq_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int EN_W   = 32;
  localparam int INJ_W  = 16;
  localparam logic [EN_W-1:0] EN_DEF = '1;

  logic              clk;
  logic              rst_n_cbi;
  logic              inject_en;
  logic              one_shot_req;
  logic [CNT_W-1:0]  hold_cycles;
  logic [CNT_W-1:0]  period_cycles;
  logic [CNT_W-1:0]  stagger_cycles;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] rst_n_out;
  logic              busy;
  logic              force_active;
  logic [EN_W-1:0]   en_force_val;
  logic [INJ_W-1:0]  inj_cnt;

  int n_cmp;
  int n_bad;
  int exp_inj;

  reset_seq_gen #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .EN_W      (EN_W),
    .EN_DEFAULT(EN_DEF),
    .INJ_CNT_W (INJ_W)
  ) u_dut (
    .clk             (clk),
    .rst_n_cbi       (rst_n_cbi),
    .inject_en_i     (inject_en),
    .one_shot_req_i  (one_shot_req),
    .hold_cycles_i   (hold_cycles),
    .period_cycles_i (period_cycles),
    .stagger_cycles_i(stagger_cycles),
    .ch_mask_i       (ch_mask),
    .rst_n_out_o     (rst_n_out),
    .busy_o          (busy),
    .force_active_o  (force_active),
    .en_force_val_o  (en_force_val),
    .inj_cnt_o       (inj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-shot injection; inputs are scrambled after ASSERT entry and a stray
  // one_shot_req is raised while busy, neither of which may alter the run.
  task automatic run_oneshot(input string tag, input int hold, input int stagger,
                             input int period, input logic [NUM_CH-1:0] mask);
    int low [NUM_CH];
    int f_cnt, b_cnt, n, hl, pl, exp_f;
    for (int i = 0; i < NUM_CH; i++) low[i] = 0;
    f_cnt = 0; b_cnt = 0; n = 0;
    hl = (hold == 0) ? 1 : hold;
    pl = (period == 0) ? 1 : period;
    exp_f = hl + (NUM_CH-1)*stagger + 1;

    @(negedge clk);
    hold_cycles    = CNT_W'(hold);
    stagger_cycles = CNT_W'(stagger);
    period_cycles  = CNT_W'(period);
    ch_mask        = mask;
    one_shot_req   = 1'b1;
    @(negedge clk);
    one_shot_req   = 1'b0;
    exp_inj++;
    chk({tag, "_first_busy_rst"}, {busy, rst_n_out}, {1'b1, ~mask});
    chk({tag, "_first_en"}, en_force_val, EN_DEF);
    chk({tag, "_inj_cnt"}, inj_cnt, exp_inj);

    ch_mask        = ~mask;
    hold_cycles    = CNT_W'(hold + 7);
    stagger_cycles = CNT_W'(stagger + 3);
    period_cycles  = CNT_W'(period + 5);
    one_shot_req   = 1'b1;

    while (busy && n < 400) begin
      for (int i = 0; i < NUM_CH; i++) if (!rst_n_out[i]) low[i]++;
      if (force_active) f_cnt++;
      b_cnt++;
      @(negedge clk);
      one_shot_req = 1'b0;
      n++;
    end
    chk({tag, "_ends_idle"}, busy, 1'b0);
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("%s_low_ch%0d", tag, i), low[i], mask[i] ? (hl + i*stagger) : 0);
    chk({tag, "_force_len"}, f_cnt, exp_f);
    chk({tag, "_busy_len"}, b_cnt, exp_f + pl);
    chk({tag, "_idle_outs"}, {force_active, rst_n_out, en_force_val}, {1'b0, 4'hF, 32'h0});
    @(negedge clk);
    chk({tag, "_stays_idle"}, {busy, inj_cnt}, {1'b1 ^ 1'b1, exp_inj[INJ_W-1:0]});
  endtask

  initial begin
    int cyc, e1, e2, end_c;
    logic prev_f;
    n_cmp = 0; n_bad = 0; exp_inj = 0;
    rst_n_cbi = 1'b0; inject_en = 1'b0; one_shot_req = 1'b0;
    hold_cycles = '0; period_cycles = '0; stagger_cycles = '0; ch_mask = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {rst_n_out, busy, force_active}, {4'hF, 1'b0, 1'b0});
    chk("reset_en_inj", {en_force_val, inj_cnt}, {32'h0, 16'h0});
    rst_n_cbi = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", busy, 1'b0);

    run_oneshot("oneshot",  5, 0, 3, 4'hF);
    run_oneshot("stagger",  3, 2, 2, 4'hF);
    run_oneshot("mask0101", 2, 1, 1, 4'b0101);
    run_oneshot("min_hold", 0, 0, 0, 4'hF);
    run_oneshot("mask0",    0, 0, 0, 4'h0);

    // Periodic, with one_shot_req also high on the request cycle.
    @(negedge clk);
    hold_cycles = 16'd4; stagger_cycles = 16'd0; period_cycles = 16'd10; ch_mask = 4'hF;
    inject_en = 1'b1; one_shot_req = 1'b1;
    cyc = 0; e1 = -1; e2 = -1; end_c = -1; prev_f = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      one_shot_req = 1'b0;
      cyc++;
      if (force_active && !prev_f) begin
        if (e1 < 0) e1 = cyc;
        else if (e2 < 0) e2 = cyc;
      end
      prev_f = force_active;
      if (e2 >= 0 && cyc == e2 + 2) inject_en = 1'b0;
      if (e2 >= 0 && !busy) begin
        end_c = cyc;
        break;
      end
    end
    inject_en = 1'b0;
    exp_inj += 2;
    chk("periodic_first_entry", e1, 1);
    chk("periodic_spacing", e2 - e1, 15);
    chk("periodic_stop_len", end_c - e2, 15);
    chk("periodic_inj_cnt", inj_cnt, exp_inj);

    // Reset asserted mid-RELEASE.
    @(negedge clk);
    hold_cycles = 16'd2; stagger_cycles = 16'd4; period_cycles = 16'd1; ch_mask = 4'hF;
    one_shot_req = 1'b1;
    @(negedge clk);
    one_shot_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrel_partial", {force_active, rst_n_out}, {1'b1, 4'b0001});
    rst_n_cbi = 1'b0;
    #1;
    chk("midrel_reset_outs", {busy, force_active, rst_n_out}, {1'b0, 1'b0, 4'hF});
    chk("midrel_reset_en_inj", {en_force_val, inj_cnt}, {32'h0, 16'h0});
    @(negedge clk);
    rst_n_cbi = 1'b1;
    exp_inj = 0;
    run_oneshot("post_reset", 1, 1, 1, 4'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
